// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide responder holding HI/LO; busy drives the hazard-unit stall.
// Optional madd (md_op 7) is compiled in when MDU_MADD_EN is defined.
module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  md_op,
   input  logic        start,
   input  logic        hl_sel,
   input  logic        req,
   output logic        busy,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {StIdle, StRun} state_e;

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;
   localparam logic [2:0] OpMadd  = 3'd7;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] phi_q, phi_d;
   logic [31:0] plo_q, plo_d;
   logic        wr_q, wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] prod_s, prod_u, madd_res;
   logic [31:0] a_abs, b_abs, q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic        madd_en, launch, idle_wr;

   // Signed product as the low 64 bits of the sign-extended 64x64 product.
   assign prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u   = {32'd0, a} * {32'd0, b};
   assign madd_res = {hi_q, lo_q} + prod_s;

`ifdef MDU_MADD_EN
   assign madd_en = 1'b1;
`else
   assign madd_en = 1'b0;
`endif

   // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
   always_comb begin
      a_abs = a[31] ? (~a + 32'd1) : a;
      b_abs = b[31] ? (~b + 32'd1) : b;
      q_mag = '0;
      r_mag = '0;
      q_u   = '0;
      r_u   = '0;
      if (b != 32'd0) begin
         q_mag = a_abs / b_abs;
         r_mag = a_abs % b_abs;
         q_u   = a / b;
         r_u   = a % b;
      end
      q_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
      r_s = a[31] ? (~r_mag + 32'd1) : r_mag;
   end

   assign idle_wr = (state_q == StIdle) && !req;
   assign launch  = idle_wr && start &&
                    ((md_op == OpMult) || (md_op == OpMultu) || (md_op == OpDiv) ||
                     (md_op == OpDivu) || (madd_en && (md_op == OpMadd)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      wr_d    = wr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (launch) begin
               state_d = StRun;
               wr_d    = 1'b1;
               cnt_d   = 32'(MULT_CYCLES);
               case (md_op)
                  OpMult:  {phi_d, plo_d} = prod_s;
                  OpMultu: {phi_d, plo_d} = prod_u;
                  OpDiv: begin
                     cnt_d = 32'(DIV_CYCLES);
                     {phi_d, plo_d} = {r_s, q_s};
                     wr_d  = (b != 32'd0);
                  end
                  OpDivu: begin
                     cnt_d = 32'(DIV_CYCLES);
                     {phi_d, plo_d} = {r_u, q_u};
                     wr_d  = (b != 32'd0);
                  end
                  default: {phi_d, plo_d} = madd_res;
               endcase
            end else if (idle_wr && (md_op == OpMthi)) begin
               hi_d = a;
            end else if (idle_wr && (md_op == OpMtlo)) begin
               lo_d = a;
            end
         end
         StRun: begin
            cnt_d = cnt_q - 32'd1;
            if (cnt_q <= 32'd1) begin
               state_d = StIdle;
               cnt_d   = '0;
               if (wr_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         wr_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         wr_q    <= wr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy    = (state_q == StRun);
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign rd_data = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, mthi/mtlo, req, reset abort, madd.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a, b;
   logic [2:0]  md_op;
   logic        start, hl_sel, req;
   logic        busy;
   logic [31:0] rd_data, hi, lo;

   int total = 0;
   int bad   = 0;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .md_op   (md_op),
      .start   (start),
      .hl_sel  (hl_sel),
      .req     (req),
      .busy    (busy),
      .rd_data (rd_data),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic move_to(input logic [2:0] op, input logic [31:0] val);
      md_op = op;
      a     = val;
      tick();
      md_op = 3'd0;
   endtask

   // Launch, count busy cycles (bounded), then check committed HI/LO and rd_data.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input int cycles,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      md_op = op;
      a     = va;
      b     = vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      md_op = 3'd0;
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check({tag, " busy cycles"}, 32'(n), 32'(cycles));
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
      hl_sel = 1'b1;
      #1;
      check({tag, " rd_data hi"}, rd_data, exp_hi);
      hl_sel = 1'b0;
      #1;
      check({tag, " rd_data lo"}, rd_data, exp_lo);
   endtask

   initial begin
      reset  = 1'b1;
      a      = '0;
      b      = '0;
      md_op  = '0;
      start  = 1'b0;
      hl_sel = 1'b0;
      req    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      check("reset busy", 32'(busy), 32'd0);

      run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
      run_op("div -7/2", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
      run_op("div min/-1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
      run_op("divu 100/7", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

      // Divide by zero keeps prior HI/LO after a full divide latency.
      move_to(3'd5, 32'h11);
      move_to(3'd6, 32'h22);
      run_op("divu by0", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);
      run_op("div by0", 3'd3, 32'hFFFFFFF9, 32'd0, 10, 32'h11, 32'h22);

      // mthi while busy is dropped; the multiply still commits.
      md_op = 3'd1; a = 32'd2; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      move_to(3'd5, 32'h1234);
      repeat (6) tick();
      check("mthi busy hi", hi, 32'h0);
      check("mthi busy lo", lo, 32'h6);
      move_to(3'd5, 32'h1234);
      check("mthi idle hi", hi, 32'h1234);
      hl_sel = 1'b1;
      #1;
      check("mthi rd_data", rd_data, 32'h1234);
      hl_sel = 1'b0;

      // req suppresses launch and moves.
      req = 1'b1; md_op = 3'd1; a = 32'd5; b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      check("req launch busy", 32'(busy), 32'd0);
      move_to(3'd6, 32'hABCD);
      req = 1'b0;
      repeat (6) tick();
      check("req hi", hi, 32'h1234);
      check("req lo", lo, 32'h6);

      // start with md_op 0 or 5 never launches; mthi still applies.
      md_op = 3'd0; start = 1'b1;
      tick();
      check("op0 start busy", 32'(busy), 32'd0);
      md_op = 3'd5; a = 32'h55;
      tick();
      start = 1'b0; md_op = 3'd0;
      check("op5 start busy", 32'(busy), 32'd0);
      check("op5 start hi", hi, 32'h55);

      // req during RUN does not abort.
      md_op = 3'd2; a = 32'd4; b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0; md_op = 3'd0; req = 1'b1;
      repeat (2) tick();
      req = 1'b0;
      repeat (4) tick();
      check("req in run busy", 32'(busy), 32'd0);
      check("req in run lo", lo, 32'd20);

      // Reset mid-divide aborts with no later commit.
      md_op = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0; md_op = 3'd0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort hi", hi, 32'h0);
      check("abort lo", lo, 32'h0);
      repeat (12) tick();
      check("abort late hi", hi, 32'h0);
      check("abort late lo", lo, 32'h0);

      // md_op 7.
      move_to(3'd5, 32'h0);
      move_to(3'd6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
      run_op("madd", 3'd7, 32'd1, 32'd1, 5, 32'h1, 32'h0);
`else
      md_op = 3'd7; a = 32'd1; b = 32'd1; start = 1'b1;
      tick();
      start = 1'b0; md_op = 3'd0;
      check("op7 busy", 32'(busy), 32'd0);
      repeat (6) tick();
      check("op7 hi", hi, 32'h0);
      check("op7 lo", lo, 32'hFFFFFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multiply/divide responder. Accepts the start pulse and 3-bit operation code that the instruction decoder issues for mult/multu/div/divu/mthi/mtlo.
- Models fixed multi-cycle latency with a busy flag that the hazard unit uses for stalling.
- Holds the architectural HI/LO registers and supplies mfhi/mflo read data.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd when enabled); legal range >= 1.
DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range >= 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
a  in  32  operand rs (forwarded E-stage value).
b  in  32  operand rt (forwarded E-stage value).
md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved/madd.
start  in  1  one-cycle launch pulse; meaningful only with md_op 1-4 (or 7 with feature).
hl_sel  in  1  read select: 1 HI, 0 LO.
req  in  1  exception/interrupt flush of the E-stage instruction this cycle.
busy  out  1  operation in flight.
rd_data  out  32  hl_sel ? hi : lo (combinational from committed registers).
hi  out  32  committed HI.
lo  out  32  committed LO.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset aborts any in-flight operation with no commit.
- States: IDLE, RUN.
  - IDLE -> RUN on an edge where start=1, req=0, md_op in {1,2,3,4}.
  - RUN -> IDLE when the counter expires.
- Launch:
  - On the accepted launch edge, compute the full result from a/b and latch it in pending {phi,plo}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the following cycle.
- Timing: a launch accepted at edge T0 keeps busy=1 for exactly N cycles. At edge T0+N: hi/lo <= pending, busy <= 0. New hi/lo are visible on rd_data in the same cycle busy falls.
- mult: signed 64-bit product; HI=[63:32], LO=[31:0].
- multu: unsigned 64-bit product; HI=[63:32], LO=[31:0].
- div: LO=quotient truncated toward zero; HI=remainder carrying the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient to LO, remainder to HI.
- Divide by zero (b=0, div or divu): full DIV_CYCLES busy period; hi/lo unchanged at commit.
- mthi/mtlo (md_op 5/6, start ignored):
  - When busy=0 and req=0, hi<=a or lo<=a at the next edge.
  - Ignored while busy=1.
- req=1 suppresses any launch, mthi or mtlo in that cycle.
- req does not abort an operation already in RUN; it completes and commits.
- start=1 while busy=1 is ignored (the pipeline stalls so this never legally occurs).
- start=1 with md_op 0, 5 or 6 does not launch.
- md_op 0, or md_op 7 without the feature: no effect.

Optional Feature:
MDU_MADD_EN
- Defined: md_op 7 with start=1 launches madd, MULT_CYCLES latency. Pending result = {hi,lo} + signed(a)*signed(b) (64-bit wrap), sampling hi/lo at launch. Commits like mult. All start/req/busy rules apply unchanged.
- Undefined: md_op 7 is a no-op, never launches, busy stays 0.

Test Plan:
1. mult: a=0xFFFFFFFE, b=3, start pulse -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 same cycle.
2. multu with the same operands -> after 5 cycles hi=0x00000002, lo=0xFFFFFFFA. div a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. divu a=7, b=0, with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
4. Launch mult, then md_op=5 with a=0x1234 while busy -> ignored; result committed as normal. mthi a=0x1234 when idle -> hi=0x1234 next cycle; hl_sel=1 gives rd_data=0x1234.
5. start=1, md_op=1, req=1 -> busy stays 0, hi/lo unchanged. Launch div, then assert reset at cycle 4 -> busy=0, hi=lo=0, no later commit.
6. With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, md_op 7, a=1, b=1 -> after 5 cycles hi=1, lo=0. Without the macro: no busy, hi/lo unchanged.
